craps_game_ctrl: RTL and testbench

CRAPS_GAME_CTRL -- requirements
Module: craps_game_ctrl

---
 rtl/craps_pkg.sv | 35 +++
 rtl/craps_roll_eval.sv | 13 +
 rtl/craps_game_ctrl.sv | 112 +++++++++++
 tb/tb_craps_game_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/craps_pkg.sv
// Shared encodings for the craps game controller: FSM states, op codes and dice sums.
package craps_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COME_REQ   = 3'd1,
    S_POINT_WAIT = 3'd2,
    S_POINT_REQ  = 3'd3,
    S_WIN        = 3'd4,
    S_LOSE       = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_INIT   = 2'b00,
    OP_REROLL = 2'b01,
    OP_WIN    = 2'b10,
    OP_LOSE   = 2'b11
  } op_t;

  localparam logic [3:0] SUM_2  = 4'd2;
  localparam logic [3:0] SUM_3  = 4'd3;
  localparam logic [3:0] SUM_7  = 4'd7;
  localparam logic [3:0] SUM_11 = 4'd11;
  localparam logic [3:0] SUM_12 = 4'd12;

  function automatic op_t state_op(input state_t s);
    case (s)
      S_POINT_WAIT, S_POINT_REQ: state_op = OP_REROLL;
      S_WIN:                     state_op = OP_WIN;
      S_LOSE:                    state_op = OP_LOSE;
      default:                   state_op = OP_INIT;
    endcase
  endfunction

endpackage

// File: rtl/craps_roll_eval.sv
// Combinational dice check: sum of both dice and whether both lie in 1..6.
module craps_roll_eval (
  input  logic [2:0] die_a,
  input  logic [2:0] die_b,
  output logic [3:0] sum,
  output logic       legal
);

  assign sum   = {1'b0, die_a} + {1'b0, die_b};
  assign legal = (die_a != 3'd0) && (die_a != 3'd7) &&
                 (die_b != 3'd0) && (die_b != 3'd7);

endmodule

// File: rtl/craps_game_ctrl.sv
// Craps game controller: requests rolls from a dice generator and tracks come-out / point phases.
module craps_game_ctrl
  import craps_pkg::*;
#(
  parameter int ROLL_CNT_W  = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  roll_btn,
  input  logic [2:0]            die_a,
  input  logic [2:0]            die_b,
  input  logic                  die_valid,
  output logic                  roll_req,
  output logic [1:0]            op,
  output logic [3:0]            sum,
  output logic [3:0]            point,
  output logic [ROLL_CNT_W-1:0] roll_cnt,
  output logic                  err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t                  state, state_nxt;
  logic [3:0]              sum_nxt, point_nxt, roll_sum;
  logic [ROLL_CNT_W-1:0]   cnt_nxt;
  logic [TW-1:0]           tmo, tmo_nxt;
  logic                    err_nxt, legal, accept;

  craps_roll_eval u_eval (
    .die_a (die_a),
    .die_b (die_b),
    .sum   (roll_sum),
    .legal (legal)
  );

  assign roll_req = (state == S_COME_REQ) || (state == S_POINT_REQ);
  assign op       = state_op(state);
  assign accept   = roll_req && die_valid && legal;

  always_comb begin
    state_nxt = state;
    sum_nxt   = sum;
    point_nxt = point;
    cnt_nxt   = roll_cnt;
    err_nxt   = err;
    tmo_nxt   = '0;
    case (state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (roll_btn) begin
          state_nxt = S_COME_REQ;
          sum_nxt   = '0;
          point_nxt = '0;
          cnt_nxt   = '0;
        end
      end
      S_POINT_WAIT: begin
        if (roll_btn) state_nxt = S_POINT_REQ;
      end
      S_COME_REQ, S_POINT_REQ: begin
        if (accept) begin
          sum_nxt = roll_sum;
          cnt_nxt = (roll_cnt == '1) ? roll_cnt : roll_cnt + 1'b1;
          if (state == S_COME_REQ) begin
            if (roll_sum == SUM_7 || roll_sum == SUM_11)
              state_nxt = S_WIN;
            else if (roll_sum == SUM_2 || roll_sum == SUM_3 || roll_sum == SUM_12)
              state_nxt = S_LOSE;
            else begin
              point_nxt = roll_sum;
              state_nxt = S_POINT_WAIT;
            end
          end else begin
            if (roll_sum == point)      state_nxt = S_WIN;
            else if (roll_sum == SUM_7) state_nxt = S_LOSE;
            else                        state_nxt = S_POINT_WAIT;
          end
        end else begin
          // An illegal die flags err but keeps the request open; only the timer ends it.
          if (die_valid) err_nxt = 1'b1;
          if (tmo == TMO_LAST) begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            tmo_nxt = tmo + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sum      <= '0;
      point    <= '0;
      roll_cnt <= '0;
      err      <= 1'b0;
      tmo      <= '0;
    end else begin
      state    <= state_nxt;
      sum      <= sum_nxt;
      point    <= point_nxt;
      roll_cnt <= cnt_nxt;
      err      <= err_nxt;
      tmo      <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_craps_game_ctrl.sv
// Bench for craps_game_ctrl: directed game scenarios plus random play against a game-rules model.
module tb_craps_game_ctrl;

  localparam int CW = 3;
  localparam int TO = 20;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          roll_btn = 1'b0;
  logic [2:0]    die_a = 3'd0, die_b = 3'd0;
  logic          die_valid = 1'b0;
  logic          roll_req;
  logic [1:0]    op;
  logic [3:0]    sum, point;
  logic [CW-1:0] roll_cnt;
  logic          err;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  craps_game_ctrl #(.ROLL_CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .roll_btn(roll_btn), .die_a(die_a), .die_b(die_b),
    .die_valid(die_valid), .roll_req(roll_req), .op(op), .sum(sum),
    .point(point), .roll_cnt(roll_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Game-rules model: phase 0 idle, 1 come-out roll pending, 2 point set,
  // 3 point roll pending, 4 won, 5 lost.
  int m_phase = 0, m_sum = 0, m_point = 0, m_cnt = 0, m_wait = 0;
  bit m_err = 1'b0;

  function automatic int m_op();
    if (m_phase == 2 || m_phase == 3) return 1;
    if (m_phase == 4) return 2;
    if (m_phase == 5) return 3;
    return 0;
  endfunction

  always @(posedge clk) begin
    int s;
    bit ok, pending;
    pending = (m_phase == 1 || m_phase == 3);
    if (rst) begin
      m_phase = 0; m_sum = 0; m_point = 0; m_cnt = 0; m_wait = 0; m_err = 0;
    end else if (pending) begin
      ok = die_a >= 1 && die_a <= 6 && die_b >= 1 && die_b <= 6;
      if (die_valid && ok) begin
        s = int'(die_a) + int'(die_b);
        m_sum = s;
        if (m_cnt < CNT_MAX) m_cnt++;
        m_wait = 0;
        if (m_phase == 1) begin
          if (s == 7 || s == 11) m_phase = 4;
          else if (s == 2 || s == 3 || s == 12) m_phase = 5;
          else begin m_point = s; m_phase = 2; end
        end else begin
          if (s == m_point) m_phase = 4;
          else if (s == 7) m_phase = 5;
          else m_phase = 2;
        end
      end else begin
        if (die_valid) m_err = 1;
        m_wait++;
        if (m_wait == TO) begin m_err = 1; m_phase = 0; m_wait = 0; end
      end
    end else if (roll_btn) begin
      if (m_phase == 2) begin
        m_phase = 3; m_wait = 0;
      end else begin
        m_phase = 1; m_sum = 0; m_point = 0; m_cnt = 0; m_wait = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("model roll_req", 32'(roll_req), 32'(m_phase == 1 || m_phase == 3));
      chk("model op", 32'(op), 32'(m_op()));
      chk("model sum", 32'(sum), 32'(m_sum));
      chk("model point", 32'(point), 32'(m_point));
      chk("model roll_cnt", 32'(roll_cnt), 32'(m_cnt));
      chk("model err", 32'(err), 32'(m_err));
    end
  end

  // Drive one cycle of inputs; return just after the edge that samples them.
  task automatic step(input logic btn, input logic dv, input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    roll_btn = btn; die_valid = dv; die_a = a; die_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(); step(1'b0, 1'b0, 3'd0, 3'd0); endtask
  task automatic btn();  step(1'b1, 1'b0, 3'd0, 3'd0); endtask
  task automatic dice(input logic [2:0] a, input logic [2:0] b); step(1'b0, 1'b1, a, b); endtask

  task automatic chk_zero(input string nm);
    chk({nm, " roll_req"}, 32'(roll_req), 0);
    chk({nm, " op"}, 32'(op), 0);
    chk({nm, " sum"}, 32'(sum), 0);
    chk({nm, " point"}, 32'(point), 0);
    chk({nm, " roll_cnt"}, 32'(roll_cnt), 0);
    chk({nm, " err"}, 32'(err), 0);
  endtask

  initial begin
    int dvp;
    rst = 1'b1;
    idle(); idle();
    chk_zero("reset");
    rst = 1'b0;
    armed = 1'b1;

    btn();
    chk("btn roll_req", 32'(roll_req), 1);
    chk("btn op", 32'(op), 0);
    dice(3, 4);
    chk("3+4 op", 32'(op), 2);
    chk("3+4 sum", 32'(sum), 7);
    chk("3+4 point", 32'(point), 0);
    chk("3+4 roll_cnt", 32'(roll_cnt), 1);
    chk("3+4 roll_req", 32'(roll_req), 0);

    btn(); dice(1, 1);
    chk("1+1 op", 32'(op), 3);
    chk("1+1 sum", 32'(sum), 2);
    btn(); dice(5, 6);
    chk("5+6 op", 32'(op), 2);
    chk("5+6 roll_cnt", 32'(roll_cnt), 1);

    btn(); dice(2, 2);
    chk("pt4 op", 32'(op), 1);
    chk("pt4 point", 32'(point), 4);
    btn(); dice(3, 3);
    chk("pt4 reroll op", 32'(op), 1);
    chk("pt4 reroll point", 32'(point), 4);
    btn(); dice(1, 3);
    chk("pt4 made op", 32'(op), 2);
    chk("pt4 made roll_cnt", 32'(roll_cnt), 3);

    btn(); dice(2, 4); btn(); dice(3, 4);
    chk("seven-out op", 32'(op), 3);
    chk("seven-out sum", 32'(sum), 7);
    chk("seven-out point", 32'(point), 6);

    btn(); dice(7, 3);
    chk("bad die err", 32'(err), 1);
    chk("bad die roll_req", 32'(roll_req), 1);
    chk("bad die roll_cnt", 32'(roll_cnt), 0);
    chk("bad die op", 32'(op), 0);
    dice(5, 6);
    chk("after bad die op", 32'(op), 2);

    // Ignored inputs: dice while no request, button while request pending.
    dice(1, 1);
    chk("stray dice op", 32'(op), 2);
    btn(); btn();
    chk("btn during req roll_req", 32'(roll_req), 1);
    step(1'b1, 1'b1, 3'd6, 3'd5);
    chk("btn+dice op", 32'(op), 2);

    rst = 1'b1; idle(); rst = 1'b0;
    btn();
    repeat (TO - 1) idle();
    chk("pre-timeout roll_req", 32'(roll_req), 1);
    idle();
    chk("timeout roll_req", 32'(roll_req), 0);
    chk("timeout err", 32'(err), 1);
    chk("timeout op", 32'(op), 0);

    btn(); dice(2, 4); btn();
    chk("point req roll_req", 32'(roll_req), 1);
    rst = 1'b1; idle(); rst = 1'b0;
    chk_zero("mid-req reset");

    btn(); dice(2, 4);
    repeat (8) begin btn(); dice(1, 1); end
    chk("saturated roll_cnt", 32'(roll_cnt), CNT_MAX);
    chk("saturated op", 32'(op), 1);

    dvp = 40;
    for (int i = 0; i < 4000; i++) begin
      logic [2:0] a, b;
      if (i % 200 == 0) dvp = ($urandom_range(0, 1) == 1) ? 40 : 3;
      a = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 6));
      b = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 6));
      rst = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 99) < dvp, a, b);
    end
    rst = 1'b0;
    idle(); idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
